sr_latch_driver: RTL and testbench

- Clocked initiator for an asynchronous set/reset latch built from a LUT with a feedback loop.
- Accepts value-change requests over a valid/ready handshake and drives non-overlapping `set`/`reset` pulses toward the latch.
- Confirms each transition by sampling the latch output `o` back through a synchronizer.
- Reports completion, or a timeout error, to the clocked domain.

---
 rtl/sr_latch_driver.sv | 184 ++++++++++++++++++
 tb/tb_sr_latch_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked initiator for a LUT feedback set/reset latch; confirms each change via synchronized fb.
// Latency: no-op request done next cycle, else pulse + GAP_CYCLES + 1; req_ready only in IDLE, valid elsewhere ignored.
// Optional SR_LATCH_DRIVER_UPSET_EN: idle-time detection of latch flips not caused by this block.
module sr_latch_driver #(
   parameter logic RVAL        = 1'b0,
   parameter logic SET_INV     = 1'b0,
   parameter logic RESET_INV   = 1'b0,
   parameter int   PULSE_MIN   = 2,
   parameter int   TIMEOUT     = 16,
   parameter int   GAP_CYCLES  = 1,
   parameter int   SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_value,
   output logic req_ready,
   input  logic fb,
   output logic set,
   output logic reset,
   output logic done,
   output logic err,
   output logic cur_value,
   output logic upset
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] PULSE_MIN_C = CNT_W'(PULSE_MIN);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [GAP_W-1:0] GAP_C       = GAP_W'(GAP_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   tgt_q, tgt_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic                   fail_q, fail_d;
   logic                   set_q, set_d;
   logic                   reset_q, reset_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   cur_value_q, cur_value_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   fb_sync;
   logic                   drive_next;
`ifdef SR_LATCH_DRIVER_UPSET_EN
   logic                   mis_q, mis_d;
   logic                   upset_q, upset_d;
`endif

   // fb is asynchronous to clk; only the last stage is ever looked at.
   assign sync_d  = {sync_q[SYNC_STAGES-2:0], fb};
   assign fb_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      fail_d      = fail_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cur_value_d = cur_value_q;
`ifdef SR_LATCH_DRIVER_UPSET_EN
      mis_d       = 1'b0;
      upset_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               tgt_d  = req_value;
               fail_d = 1'b0;
               if ((req_value == cur_value_q) && (fb_sync == req_value)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_DRIVE;
                  cnt_d   = CNT_W'(1);
               end
            end else begin
`ifdef SR_LATCH_DRIVER_UPSET_EN
               // A flip must persist two idle cycles before it is believed.
               if (fb_sync != cur_value_q) begin
                  if (mis_q) begin
                     upset_d     = 1'b1;
                     cur_value_d = fb_sync;
                  end else begin
                     mis_d = 1'b1;
                  end
               end
`endif
            end
         end
         S_DRIVE: begin
            if ((cnt_q >= PULSE_MIN_C) && (fb_sync == tgt_q)) begin
               state_d     = S_GAP;
               gap_d       = GAP_W'(1);
               cur_value_d = tgt_q;
            end else if (cnt_q >= TIMEOUT_C) begin
               state_d     = S_GAP;
               gap_d       = GAP_W'(1);
               fail_d      = 1'b1;
               cur_value_d = fb_sync;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (gap_q >= GAP_C) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = fail_q;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pins follow the next state so the pulse starts on the accept edge and both are never active together.
      drive_next = (state_d == S_DRIVE);
      set_d      = (drive_next & tgt_d) ^ SET_INV;
      reset_d    = (drive_next & ~tgt_d) ^ RESET_INV;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         tgt_q       <= RVAL;
         cnt_q       <= '0;
         gap_q       <= '0;
         fail_q      <= 1'b0;
         set_q       <= SET_INV;
         reset_q     <= RESET_INV;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cur_value_q <= RVAL;
         sync_q      <= {SYNC_STAGES{RVAL}};
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         fail_q      <= fail_d;
         set_q       <= set_d;
         reset_q     <= reset_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cur_value_q <= cur_value_d;
         sync_q      <= sync_d;
      end
   end

`ifdef SR_LATCH_DRIVER_UPSET_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_q   <= 1'b0;
         upset_q <= 1'b0;
      end else begin
         mis_q   <= mis_d;
         upset_q <= upset_d;
      end
   end
   assign upset = upset_q;
`else
   assign upset = 1'b0;
`endif

   assign req_ready = (state_q == S_IDLE);
   assign set       = set_q;
   assign reset     = reset_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cur_value = cur_value_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural latch model plus a transaction-level expectation per request.
module tb_sr_latch_driver;

   localparam logic RVAL        = 1'b0;
   localparam logic SET_INV     = 1'b0;
   localparam logic RESET_INV   = 1'b0;
   localparam int   PULSE_MIN   = 2;
   localparam int   TIMEOUT     = 16;
   localparam int   GAP_CYCLES  = 1;
   localparam int   SYNC_STAGES = 2;
   // A working latch answers at once, so the match is seen once fb has crossed the synchronizer.
   localparam int   LEN_NORMAL  = (PULSE_MIN > SYNC_STAGES + 1) ? PULSE_MIN : SYNC_STAGES + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_valid = 1'b0;
   logic req_value = 1'b0;
   logic req_ready, fb, set, reset, done, err, cur_value, upset;
   logic set_act, reset_act;

   int n_vec = 0;
   int n_err = 0;
   logic m_cur = RVAL;

   // Latch model: follows the pins unless stuck; kick forces a value as an outside upset would.
   logic lat = RVAL;
   logic stuck = 1'b0;
   logic kick = 1'b0;
   logic kick_seen = 1'b0;
   logic kick_val = 1'b0;

   always #5 clk = ~clk;

   sr_latch_driver #(
      .RVAL(RVAL), .SET_INV(SET_INV), .RESET_INV(RESET_INV), .PULSE_MIN(PULSE_MIN),
      .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
      .req_ready(req_ready), .fb(fb), .set(set), .reset(reset), .done(done),
      .err(err), .cur_value(cur_value), .upset(upset)
   );

   assign set_act   = set ^ SET_INV;
   assign reset_act = reset ^ RESET_INV;
   assign fb        = lat;

   always @(set_act, reset_act, kick) begin
      if (kick != kick_seen) begin
         lat       = kick_val;
         kick_seen = kick;
      end else if (!stuck) begin
         if (set_act) lat = 1'b1;
         else if (reset_act) lat = 1'b0;
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) check_val("ready_wait_timeout", 0, 1);
   endtask

   // mode 0: working latch, 1: latch stuck at its present value, 2: latch flipped to target beforehand.
   task automatic do_req(input logic tgt, input int mode);
      int   exp_len, exp_done, ups;
      logic exp_err, exp_cur;
      int   on_cnt, wrong_cnt, first_on, last_on, ovl, stray, done_at, err_at, cur_at, rdy_at;
      logic act, oth;

      if (mode == 2 && tgt != m_cur) begin
         kick_val = tgt;
         kick     = ~kick;
         ups      = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (upset) ups++;
         end
`ifdef SR_LATCH_DRIVER_UPSET_EN
         check_val("upset_pulses", ups, 1);
         m_cur = tgt;
`else
         check_val("upset_pulses", ups, 0);
`endif
         check_val("cur_after_flip", cur_value, m_cur);
      end

      stuck    = (mode == 1);
      exp_err  = 1'b0;
      exp_cur  = tgt;
      if (tgt == m_cur) exp_len = 0;
      else if (mode == 1) begin
         exp_len = TIMEOUT;
         exp_err = 1'b1;
         exp_cur = m_cur;
      end else if (mode == 2) exp_len = PULSE_MIN;
      else exp_len = LEN_NORMAL;
      exp_done = (exp_len == 0) ? 1 : exp_len + GAP_CYCLES + 1;

      wait_ready();
      req_valid = 1'b1;
      req_value = tgt;
      @(negedge clk);
      req_valid = 1'b0;
      req_value = $urandom_range(0, 1);

      on_cnt = 0; wrong_cnt = 0; first_on = 0; last_on = 0; ovl = 0; stray = 0;
      done_at = 0; err_at = 0; cur_at = 0; rdy_at = 0;
      for (int c = 1; c <= TIMEOUT + GAP_CYCLES + 10; c++) begin
         act = tgt ? set_act : reset_act;
         oth = tgt ? reset_act : set_act;
         if (act) begin
            on_cnt++;
            if (first_on == 0) first_on = c;
            last_on = c;
         end
         if (oth) wrong_cnt++;
         if (set_act && reset_act) ovl++;
         if ((err && !done) || upset) stray++;
         if (done) begin
            done_at = c;
            err_at  = err;
            cur_at  = cur_value;
            rdy_at  = req_ready;
            break;
         end
         @(negedge clk);
      end

      check_val("pulse_len", on_cnt, exp_len);
      check_val("pulse_first", first_on, (exp_len == 0) ? 0 : 1);
      check_val("pulse_last", last_on, exp_len);
      check_val("wrong_pin", wrong_cnt, 0);
      check_val("pin_overlap", ovl, 0);
      check_val("stray_err_upset", stray, 0);
      check_val("done_cycle", done_at, exp_done);
      check_val("err_at_done", err_at, exp_err);
      check_val("cur_at_done", cur_at, exp_cur);
      check_val("ready_at_done", rdy_at, 1);
      m_cur = exp_cur;
      stuck = 1'b0;
   endtask

   initial begin
      int dcnt;
      logic t;
      repeat (3) @(negedge clk);
      check_val("rst_ready", req_ready, 1);
      check_val("rst_set", set_act, 0);
      check_val("rst_reset", reset_act, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_upset", upset, 0);
      check_val("rst_cur", cur_value, RVAL);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      do_req(1'b1, 0);
      do_req(1'b0, 0);
      do_req(1'b1, 0);
      do_req(1'b1, 0);
      do_req(1'b0, 0);
      do_req(1'b1, 1);
      do_req(1'b1, 2);
      do_req(1'b0, 2);

      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         t = $urandom_range(0, 1);
         do_req(t, $urandom_range(0, 2));
      end

      // Reset asserted in the second DRIVE cycle of a set pulse.
      if (m_cur) do_req(1'b0, 0);
      wait_ready();
      req_valid = 1'b1;
      req_value = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check_val("mid_rst_pre_set", set_act, 1);
      #2 rst = 1'b0;
      #1;
      check_val("mid_rst_set_async", set_act, 0);
      check_val("mid_rst_reset", reset_act, 0);
      check_val("mid_rst_ready", req_ready, 1);
      check_val("mid_rst_cur", cur_value, RVAL);
      check_val("mid_rst_done", done, 0);
      kick_val = RVAL;
      kick     = ~kick;
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      m_cur = RVAL;
      dcnt  = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || set_act || reset_act) dcnt++;
      end
      check_val("post_rst_quiet", dcnt, 0);
      check_val("post_rst_ready", req_ready, 1);
      do_req(1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, elapsed %0t, limit 500000", $time);
      $fatal(1);
   end

endmodule
